modular_inverse: RTL and testbench



---
 rtl/ntt_pkg.sv | 19 +
 rtl/modular_inverse_half.sv | 26 ++
 rtl/modular_inverse.sv | 164 ++++++++++++++++
 tb/tb_modular_inverse.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT definitions: datapath width, default modulus and the
// state encoding of the modular inverse unit.
package ntt_pkg;

  localparam int W = 28;

  // 2^28 - 2^16 + 1, the NTT prime used throughout the datapath.
  localparam logic [W-1:0] Q_DEFAULT = 28'd268369921;

  typedef logic [W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/modular_inverse_half.sv
// Modular halving: returns x/2 mod q for odd q and x in [0,q).
// An odd x is made even by adding q first. The sum is formed at W+1 bits
// so that the carry is not lost.
module mod_half
  import ntt_pkg::*;
#(
  parameter int HW = W
) (
  input  logic [HW-1:0] x_i,
  input  logic [HW-1:0] q_i,
  output logic [HW-1:0] half_o
);

  logic [HW:0] sum;

  // Add q only when x is odd, so the shift below is exact.
  always_comb begin
    sum = {1'b0, x_i};
    if (x_i[0]) begin
      sum = {1'b0, x_i} + {1'b0, q_i};
    end
  end

  assign half_o = sum[HW:1];

endmodule

// File: rtl/modular_inverse.sv
// Iterative modular inverse using the binary extended Euclid algorithm.
// The unit performs one step per clock. Invariants: x1*a == u (mod q) and
// x2*a == v (mod q), with x1 and x2 always in [0,q).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE. out_valid is high only in DONE,
// and out and err stay constant until out_ready is seen. Because in_ready is
// low in DONE, a request cannot be taken in the same cycle as the result
// handshake. It is taken in the following IDLE cycle.
module modular_inverse
  import ntt_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] q,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         err,
  output logic [1:0]   dbg_state_o
);

  state_t       state_q, state_d;
  logic [W-1:0] u_q, u_d;
  logic [W-1:0] v_q, v_d;
  logic [W-1:0] x1_q, x1_d;
  logic [W-1:0] x2_q, x2_d;
  logic [W-1:0] qr_q, qr_d;
  logic [W-1:0] out_q, out_d;
  logic         err_q, err_d;

  logic [W-1:0] x1_half, x2_half;
  logic [W:0]   diff12, diff21;
  logic [W-1:0] sub12, sub21;

  mod_half #(.HW(W)) u_half_x1 (
    .x_i    (x1_q),
    .q_i    (qr_q),
    .half_o (x1_half)
  );

  mod_half #(.HW(W)) u_half_x2 (
    .x_i    (x2_q),
    .q_i    (qr_q),
    .half_o (x2_half)
  );

  // Modular subtraction in both directions. A negative difference wraps
  // modulo 2^W, and adding qr brings it back into [0,qr).
  always_comb begin
    diff12 = {1'b0, x1_q} - {1'b0, x2_q};
    diff21 = {1'b0, x2_q} - {1'b0, x1_q};
    sub12  = diff12[W] ? (diff12[W-1:0] + qr_q) : diff12[W-1:0];
    sub21  = diff21[W] ? (diff21[W-1:0] + qr_q) : diff21[W-1:0];
  end

  // Next-state and datapath update. Every register keeps its value unless
  // the current state changes it.
  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    qr_d    = qr_q;
    out_d   = out_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          u_d     = a;
          v_d     = q;
          x1_d    = {{(W-1){1'b0}}, 1'b1};
          x2_d    = '0;
          qr_d    = q;
          out_d   = '0;
          err_d   = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (u_q == '0 || u_q >= qr_q) begin
          err_d   = 1'b1;
          out_d   = '0;
          state_d = DONE;
        end else if (u_q == W'(1)) begin
          out_d   = W'(1);
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (u_q == W'(1)) begin
          out_d   = x1_q;
          state_d = DONE;
        end else if (v_q == W'(1)) begin
          out_d   = x2_q;
          state_d = DONE;
        end else if (u_q == '0 || v_q == '0) begin
          // u and v share a factor, so they can never reach 1.
          err_d   = 1'b1;
          out_d   = '0;
          state_d = DONE;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = x1_half;
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = x2_half;
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = sub12;
        end else begin
          v_d  = v_q - u_q;
          x2_d = sub21;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset aborts any operation in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      u_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      qr_q    <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      qr_q    <= qr_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out         = out_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

  // The algorithm is only defined for odd moduli.
  a_q_odd: assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE && in_valid) |-> q[0]);

endmodule

// File: tb/tb_modular_inverse.sv
// Directed and reference-checked tests for modular_inverse.
module tb_modular_inverse;
  import ntt_pkg::*;

  localparam int          LAT_MAX = 4 * W + 4;
  localparam int          TIMEOUT = 400;
  localparam logic [63:0] QD      = 64'd268369921;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] q;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         err;
  logic [1:0]   dbg_state;

  int n_total;
  int n_bad;

  modular_inverse dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .q           (q),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out),
    .err         (err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Present a request. Wait (bounded) for in_ready, then hold in_valid
  // through one rising edge.
  task automatic send_req(input logic [W-1:0] ta, input logic [W-1:0] tq);
    int n;
    n = 0;
    while (!in_ready && n < TIMEOUT) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("req_ready_timeout", 64'(n < TIMEOUT), 64'd1);
    a        = ta;
    q        = tq;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count cycles from the accept edge until out_valid is seen.
  task automatic wait_result(output logic [W-1:0] r, output logic e,
                             output int lat);
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("result_timeout", 64'(out_valid), 64'd1);
    r = out;
    e = err;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // Full transaction with a known expected result.
  task automatic run_exp(input string tag, input logic [W-1:0] ta,
                         input logic [W-1:0] tq, input logic [W-1:0] exp_out,
                         input logic exp_err);
    logic [W-1:0] r;
    logic         e;
    int           lat;
    send_req(ta, tq);
    wait_result(r, e, lat);
    check({tag, "_out"}, 64'(r), 64'(exp_out));
    check({tag, "_err"}, 64'(e), 64'(exp_err));
    check({tag, "_lat"}, 64'(lat <= LAT_MAX), 64'd1);
    ack();
    check({tag, "_idle"}, 64'(in_ready), 64'd1);
    check({tag, "_ovld_low"}, 64'(out_valid), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] r;
    logic [W-1:0] ra;
    logic         e;
    int           lat;
    logic [63:0]  prod;
    logic [W-1:0] held_out;
    logic         held_err;
    int           hold_bad;

    n_total   = 0;
    n_bad     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    q         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // a=1 finishes in CHECK: out_valid within 2 cycles of the accept.
    send_req(W'(1), Q_DEFAULT);
    wait_result(r, e, lat);
    check("a1_out", 64'(r), 64'd1);
    check("a1_err", 64'(e), 64'd0);
    check("a1_lat", 64'(lat <= 2), 64'd1);
    ack();

    // Directed vectors with hand-computed inverses.
    run_exp("a2", W'(2), Q_DEFAULT, W'(134184961), 1'b0);
    run_exp("aqm1", W'(268369920), Q_DEFAULT, W'(268369920), 1'b0);
    run_exp("a3", W'(3), Q_DEFAULT, W'(178913281), 1'b0);
    run_exp("q15a7", W'(7), W'(15), W'(13), 1'b0);
    run_exp("q15a2", W'(2), W'(15), W'(8), 1'b0);
    run_exp("q7a3", W'(3), W'(7), W'(5), 1'b0);

    // Cases with no inverse.
    run_exp("a0", W'(0), Q_DEFAULT, W'(0), 1'b1);
    run_exp("aeqq", Q_DEFAULT, Q_DEFAULT, W'(0), 1'b1);
    run_exp("q15a6", W'(6), W'(15), W'(0), 1'b1);

    // Random operands checked against (a*out) mod q == 1.
    for (int i = 0; i < 300; i++) begin
      ra = W'($urandom_range(1, 268369920));
      send_req(ra, Q_DEFAULT);
      wait_result(r, e, lat);
      prod = (64'(ra) * 64'(r)) % QD;
      check("rnd_prod", prod, 64'd1);
      check("rnd_err", 64'(e), 64'd0);
      check("rnd_lat", 64'(lat <= LAT_MAX), 64'd1);
      ack();
    end

    // Back-pressure: hold out_ready low while a new request waits.
    send_req(W'(2), Q_DEFAULT);
    wait_result(r, e, lat);
    check("bp_out", 64'(r), 64'd134184961);
    held_out = out;
    held_err = err;
    a        = W'(3);
    q        = Q_DEFAULT;
    in_valid = 1'b1;
    hold_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out !== held_out || err !== held_err || in_ready !== 1'b0 ||
          out_valid !== 1'b1) begin
        hold_bad++;
      end
    end
    check("bp_hold_stable", 64'(hold_bad), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_idle_after_ack", 64'(in_ready), 64'd1);
    check("bp_ovld_after_ack", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_accepted", 64'(in_ready), 64'd0);
    wait_result(r, e, lat);
    check("bp_next_out", 64'(r), 64'd178913281);
    check("bp_next_err", 64'(e), 64'd0);
    ack();

    // Reset in the middle of RUN aborts the operation.
    send_req(W'(12345), Q_DEFAULT);
    repeat (10) @(posedge clk);
    #1;
    check("mid_state_run", 64'(dbg_state), 64'(RUN));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    run_exp("post_rst_a2", W'(2), Q_DEFAULT, W'(134184961), 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
